fp_product_accumulator: RTL and testbench



---
 rtl/fp_product_accumulator.sv | 218 +++++++++++++++++++++
 tb/tb_fp_product_accumulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_product_accumulator.sv
// Multi-cycle FP32 accumulator fed by a product stream; one shared adder walks each
// operand through ALIGN/ADD/NORM/PACK and delivers the group total when the last operand lands.
module fp_product_accumulator #(
  parameter logic [31:0] ACC_INIT  = 32'h0000_0000,
  parameter int unsigned SHIFT_MAX = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_overflow,
  output logic        busy
);

  localparam logic [7:0] ShiftMax = 8'(SHIFT_MAX);

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StPack, StOut} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [31:0] op_q;
  logic        last_q;

  // Operands after alignment: A has the larger exponent, B is shifted to match.
  logic        sign_a_q, sign_b_q;
  logic [7:0]  exp_a_q;
  logic [23:0] man_a_q, man_b_q;
  logic        byp_q, byp_ovf_q;
  logic [31:0] byp_val_q;

  logic        sign_r_q;
  logic [24:0] sum_q;

  logic [31:0] res_q;
  logic        res_ovf_q;

  // ALIGN datapath
  logic [7:0]  acc_exp, op_exp, big_exp, small_exp, exp_diff;
  logic [23:0] acc_man, op_man, big_man, small_man, small_aligned;
  logic        big_sign, small_sign, swap;
  logic        byp_d, byp_ovf_d;
  logic [31:0] byp_val_d;

  always_comb begin
    acc_exp       = acc_q[30:23];
    op_exp        = op_q[30:23];
    acc_man       = (acc_exp == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
    op_man        = (op_exp == 8'd0) ? 24'd0 : {1'b1, op_q[22:0]};
    swap          = op_exp > acc_exp;
    big_exp       = swap ? op_exp : acc_exp;
    small_exp     = swap ? acc_exp : op_exp;
    big_man       = swap ? op_man : acc_man;
    small_man     = swap ? acc_man : op_man;
    big_sign      = swap ? op_q[31] : acc_q[31];
    small_sign    = swap ? acc_q[31] : op_q[31];
    exp_diff      = big_exp - small_exp;
    small_aligned = (exp_diff >= ShiftMax) ? 24'd0 : (small_man >> exp_diff);

    // An infinite accumulator absorbs the rest of the group; an infinite input saturates it.
    byp_d     = 1'b0;
    byp_val_d = acc_q;
    byp_ovf_d = 1'b0;
    if (acc_exp == 8'hff) begin
      byp_d = 1'b1;
    end else if (op_exp == 8'hff) begin
      byp_d     = 1'b1;
      byp_val_d = {op_q[31], 8'hff, 23'd0};
      byp_ovf_d = 1'b1;
    end
  end

  // ADD datapath
  logic [24:0] sum_d;
  logic        sign_r_d;

  always_comb begin
    if (sign_a_q == sign_b_q) begin
      sum_d    = {1'b0, man_a_q} + {1'b0, man_b_q};
      sign_r_d = sign_a_q;
    end else if (man_a_q >= man_b_q) begin
      sum_d    = {1'b0, man_a_q} - {1'b0, man_b_q};
      sign_r_d = sign_a_q;
    end else begin
      sum_d    = {1'b0, man_b_q} - {1'b0, man_a_q};
      sign_r_d = sign_b_q;
    end
  end

  // NORM datapath
  logic [4:0]        lzc;
  logic              found;
  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;
  logic [31:0]       res_d;
  logic              res_ovf_d;

  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && sum_q[i]) begin
        found = 1'b1;
        lzc   = 5'(23 - i);
      end
    end
  end

  always_comb begin
    if (sum_q[24]) begin
      frac_n = sum_q[23:1];
      exp_n  = $signed({2'b00, exp_a_q}) + 10'sd1;
    end else begin
      // Leading one is shifted out of the 23-bit field, leaving the fraction.
      frac_n = sum_q[22:0] << lzc;
      exp_n  = $signed({2'b00, exp_a_q}) - $signed({5'd0, lzc});
    end

    res_ovf_d = 1'b0;
    if (byp_q) begin
      res_d     = byp_val_q;
      res_ovf_d = byp_ovf_q;
    end else if (sum_q == 25'd0 || exp_n < 10'sd1) begin
      res_d = 32'd0;
    end else if (exp_n >= 10'sd255) begin
      res_d     = {sign_r_q, 8'hff, 23'd0};
      res_ovf_d = 1'b1;
    end else begin
      res_d = {sign_r_q, exp_n[7:0], frac_n};
    end
  end

  // Control
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StPack;
      StPack: begin
        acc_d   = res_q;
        ovf_d   = ovf_q | res_ovf_q;
        state_d = last_q ? StOut : StIdle;
      end
      StOut: begin
        if (out_ready) begin
          acc_d   = ACC_INIT;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= ACC_INIT;
      ovf_q     <= 1'b0;
      op_q      <= 32'd0;
      last_q    <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      exp_a_q   <= 8'd0;
      man_a_q   <= 24'd0;
      man_b_q   <= 24'd0;
      byp_q     <= 1'b0;
      byp_ovf_q <= 1'b0;
      byp_val_q <= 32'd0;
      sign_r_q  <= 1'b0;
      sum_q     <= 25'd0;
      res_q     <= 32'd0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      if (state_q == StIdle && in_valid) begin
        op_q   <= in_data;
        last_q <= in_last;
      end
      if (state_q == StAlign) begin
        sign_a_q  <= big_sign;
        sign_b_q  <= small_sign;
        exp_a_q   <= big_exp;
        man_a_q   <= big_man;
        man_b_q   <= small_aligned;
        byp_q     <= byp_d;
        byp_ovf_q <= byp_ovf_d;
        byp_val_q <= byp_val_d;
      end
      if (state_q == StAdd) begin
        sum_q    <= sum_d;
        sign_r_q <= sign_r_d;
      end
      if (state_q == StNorm) begin
        res_q     <= res_d;
        res_ovf_q <= res_ovf_d;
      end
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StOut);
  assign out_sum      = out_valid ? acc_q : 32'd0;
  assign out_overflow = out_valid & ovf_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_fp_product_accumulator.sv
// Directed and randomized bench for fp_product_accumulator against a value-level FP32
// truncating-adder reference model.
module tb_fp_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_overflow;
  logic        busy;

  int          cmp_n = 0;
  int          err_n = 0;
  logic [31:0] mdl_acc = 32'd0;
  logic        mdl_ovf = 1'b0;

  fp_product_accumulator #(
    .ACC_INIT (32'h0000_0000),
    .SHIFT_MAX(25)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_overflow(out_overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Returns {overflow, result} of acc + op with truncation and flush-to-zero.
  function automatic logic [32:0] ref_add(input logic [31:0] acc, input logic [31:0] op);
    int     ea, eb, e, d, ti;
    longint ma, mb, s, mag, tl;
    logic   sa, sb, tb, sg;
    if (acc[30:23] == 8'hff) return {1'b0, acc};
    if (op[30:23] == 8'hff) return {1'b1, op[31], 8'hff, 23'd0};
    ea = int'(acc[30:23]);
    eb = int'(op[30:23]);
    ma = (ea == 0) ? 64'd0 : longint'({1'b1, acc[22:0]});
    mb = (eb == 0) ? 64'd0 : longint'({1'b1, op[22:0]});
    sa = acc[31];
    sb = op[31];
    if (eb > ea) begin
      ti = ea; ea = eb; eb = ti;
      tl = ma; ma = mb; mb = tl;
      tb = sa; sa = sb; sb = tb;
    end
    d  = ea - eb;
    mb = (d >= 25) ? 64'd0 : (mb >> d);
    s  = (sa ? -ma : ma) + (sb ? -mb : mb);
    if (s == 0) return 33'd0;
    sg  = (s < 0);
    mag = sg ? -s : s;
    e   = ea;
    while (mag >= (longint'(1) << 24)) begin
      mag = mag >> 1;
      e++;
    end
    while (mag < (longint'(1) << 23)) begin
      mag = mag << 1;
      e--;
    end
    if (e >= 255) return {1'b1, sg, 8'hff, 23'd0};
    if (e < 1) return 33'd0;
    return {1'b0, sg, 8'(e), mag[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int         p;
    p = $urandom_range(0, 39);
    if (p == 0) e = 8'd0;
    else if (p == 1) e = 8'hff;
    else if (p == 2) e = 8'd254;
    else e = 8'($urandom_range(118, 136));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_n++;
    assert (obs === expv) else begin
      err_n++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand, waiting (bounded) for in_ready; returns #1 after the accept edge.
  task automatic send(input logic [31:0] d, input logic l);
    logic [32:0] r;
    int          n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'b0;
    r        = ref_add(mdl_acc, d);
    mdl_acc  = r[31:0];
    mdl_ovf  = mdl_ovf | r[32];
  endtask

  task automatic recv(input string tag, input logic [31:0] es, input logic eo, input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    repeat (hold) step();
    check({tag, "_sum"}, out_sum, es);
    check({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, eo});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    mdl_acc   = 32'd0;
    mdl_ovf   = 1'b0;
  endtask

  initial begin
    logic [31:0] cap;
    int          busy_cnt;
    int          nops;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_ovf", {31'd0, out_overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // 2.0 + 3.0 with latency check on the last operand
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b1);
    repeat (3) step();
    check("lat_early", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_rise", {31'd0, out_valid}, 32'd1);
    recv("two_plus_three", 32'h40A0_0000, 1'b0, 0);

    send(32'h3FF0_0000, 1'b0);
    send(32'hC32F_0000, 1'b1);
    recv("mixed_sign", 32'hC32D_2000, 1'b0, 1);

    send(32'h4254_0000, 1'b0);
    send(32'hC254_0000, 1'b1);
    recv("cancel", 32'h0000_0000, 1'b0, 0);

    // Single-operand group; busy must span exactly five cycles with out_ready held high
    out_ready = 1'b1;
    send(32'h45A8_F000, 1'b1);
    busy_cnt = 0;
    cap      = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cnt++;
      if (out_valid) cap = out_sum;
      step();
    end
    out_ready = 1'b0;
    mdl_acc   = 32'd0;
    mdl_ovf   = 1'b0;
    check("single_sum", cap, 32'h45A8_F000);
    check("single_busy", busy_cnt, 32'd5);

    // Saturation, then stall the output while upstream keeps offering data
    send(32'h7F7F_FFFF, 1'b0);
    send(32'h7F7F_FFFF, 1'b0);
    send(32'h3F80_0000, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        step();
        n++;
      end
    end
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_sum", out_sum, 32'h7F80_0000);
      check("stall_ovf", {31'd0, out_overflow}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    recv("overflow", 32'h7F80_0000, 1'b1, 0);

    // Reset while the operand sits in ADD
    send(32'h4100_0000, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst     = 1'b0;
    mdl_acc = 32'd0;
    mdl_ovf = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    send(32'h4000_0000, 1'b1);
    recv("after_rst", 32'h4000_0000, 1'b0, 0);

    // Random groups against the reference model
    for (int g = 0; g < 30; g++) begin
      nops = $urandom_range(1, 5);
      for (int k = 0; k < nops; k++) begin
        repeat ($urandom_range(0, 2)) step();
        send(rand_fp(), (k == nops - 1));
      end
      recv("rnd", mdl_acc, mdl_ovf, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
